// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: debounces a timing-mode request, issues the
// three-write fractional-M reconfiguration over the management port, then waits for re-lock.
module pll_reconfig_seq #(
  parameter logic [31:0] FRAC_NATIVE  = 32'd3639383488,
  parameter logic [31:0] FRAC_ADJ     = 32'd3262113561,
  parameter logic [5:0]  FRAC_ADDR    = 6'd7,
  parameter int          LOCK_STABLE  = 8,
  parameter logic [19:0] LOCK_TIMEOUT = 20'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode_req,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        mode_applied,
  output logic        done,
  output logic        error
);

  localparam int LW = $clog2(LOCK_STABLE + 1);
  localparam logic [LW-1:0] LOCK_STABLE_C = LW'(LOCK_STABLE);

  typedef enum logic [3:0] {
    IDLE, W_MODE, GAP_MODE, W_FRAC, GAP_FRAC, W_START, GAP_START, WAIT_BUSY, WAIT_LOCK
  } state_t;

  state_t        state, state_nxt;
  logic          mode_s1, mode_s2, lock_s1, lock_s2;
  logic          target, target_nxt;
  logic [1:0]    wb_cnt, wb_nxt;
  logic [LW-1:0] lock_cnt, lock_nxt, lock_inc;
  logic [19:0]   to_cnt, to_nxt, to_inc;
  logic          write_nxt, busy_nxt, applied_nxt, done_nxt, error_nxt;
  logic [5:0]    addr_nxt;
  logic [31:0]   data_nxt;

  // Handshake: a write strobe is registered only from a cycle in which
  // mgmt_waitrequest was sampled low; it lasts one cycle and is never held.
  always_comb begin
    state_nxt   = state;
    target_nxt  = target;
    wb_nxt      = wb_cnt;
    lock_nxt    = lock_cnt;
    to_nxt      = to_cnt;
    write_nxt   = 1'b0;
    addr_nxt    = mgmt_address;
    data_nxt    = mgmt_writedata;
    busy_nxt    = busy;
    applied_nxt = mode_applied;
    done_nxt    = 1'b0;
    error_nxt   = error;
    lock_inc    = lock_s2 ? lock_cnt + 1'b1 : '0;
    to_inc      = to_cnt + 20'd1;

    case (state)
      IDLE: begin
        // Two equal sync stages reject single-cycle glitches on mode_req.
        if (mode_s1 == mode_s2 && mode_s2 != mode_applied) begin
          target_nxt = mode_s2;
          busy_nxt   = 1'b1;
          state_nxt  = W_MODE;
        end
      end
      W_MODE: begin
        if (!mgmt_waitrequest) begin
          write_nxt = 1'b1;
          addr_nxt  = 6'd0;
          data_nxt  = 32'd0;
          state_nxt = GAP_MODE;
        end
      end
      GAP_MODE: state_nxt = W_FRAC;
      W_FRAC: begin
        if (!mgmt_waitrequest) begin
          write_nxt = 1'b1;
          addr_nxt  = FRAC_ADDR;
          data_nxt  = target ? FRAC_ADJ : FRAC_NATIVE;
          state_nxt = GAP_FRAC;
        end
      end
      GAP_FRAC: state_nxt = W_START;
      W_START: begin
        if (!mgmt_waitrequest) begin
          write_nxt = 1'b1;
          addr_nxt  = 6'd2;
          data_nxt  = 32'd0;
          state_nxt = GAP_START;
        end
      end
      GAP_START: begin
        wb_nxt    = 2'd0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // waitrequest may still be low right after the start write; skip two cycles.
        if (wb_cnt != 2'd2) begin
          wb_nxt = wb_cnt + 2'd1;
        end else if (!mgmt_waitrequest) begin
          lock_nxt  = '0;
          to_nxt    = '0;
          state_nxt = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        lock_nxt = lock_inc;
        to_nxt   = to_inc;
        if (lock_inc == LOCK_STABLE_C) begin
          applied_nxt = target;
          error_nxt   = 1'b0;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end else if (to_inc == LOCK_TIMEOUT) begin
          error_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      mode_s1        <= 1'b0;
      mode_s2        <= 1'b0;
      lock_s1        <= 1'b0;
      lock_s2        <= 1'b0;
      target         <= 1'b0;
      wb_cnt         <= '0;
      lock_cnt       <= '0;
      to_cnt         <= '0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      busy           <= 1'b0;
      mode_applied   <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_nxt;
      mode_s1        <= mode_req;
      mode_s2        <= mode_s1;
      lock_s1        <= pll_locked;
      lock_s2        <= lock_s1;
      target         <= target_nxt;
      wb_cnt         <= wb_nxt;
      lock_cnt       <= lock_nxt;
      to_cnt         <= to_nxt;
      mgmt_write     <= write_nxt;
      mgmt_address   <= addr_nxt;
      mgmt_writedata <= data_nxt;
      busy           <= busy_nxt;
      mode_applied   <= applied_nxt;
      done           <= done_nxt;
      error          <= error_nxt;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: write order/data, waitrequest hold,
// lock timeout and retry, reset abort, and mode_req glitch rejection.
module tb_pll_reconfig_seq;
  localparam logic [31:0] FRAC_NATIVE = 32'd3639383488;
  localparam logic [31:0] FRAC_ADJ    = 32'd3262113561;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode_req = 1'b0;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b1;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        busy, mode_applied, done, error;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int b2b = 0;
  logic prev_wr = 1'b0;
  logic [37:0] got_q[$];
  int          got_cyc[$];
  logic [37:0] exp_q[$];

  pll_reconfig_seq #(.LOCK_TIMEOUT(20'd100)) dut (
    .clk(clk), .reset(reset), .mode_req(mode_req),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
    .mgmt_write(mgmt_write), .mgmt_address(mgmt_address),
    .mgmt_writedata(mgmt_writedata), .busy(busy),
    .mode_applied(mode_applied), .done(done), .error(error)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // write capture
  always @(negedge clk) begin
    if (mgmt_write) begin
      got_q.push_back({mgmt_address, mgmt_writedata});
      got_cyc.push_back(cyc);
      if (prev_wr) b2b <= b2b + 1;
    end
    prev_wr <= mgmt_write;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk_bit(tag, done, 1'b1);
  endtask

  task automatic wait_write(input string tag, input int budget);
    int n = 0;
    while (mgmt_write !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk_bit(tag, mgmt_write, 1'b1);
  endtask

  task automatic clear_capture();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic push_seq(input logic [31:0] frac);
    exp_q.push_back({6'd0, 32'd0});
    exp_q.push_back({6'd7, frac});
    exp_q.push_back({6'd2, 32'd0});
  endtask

  task automatic compare_writes(input string tag);
    chk_int($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk_val($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    int n;
    int hi;

    // reset state
    tick(3);
    chk_bit("rst_write", mgmt_write, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_applied", mode_applied, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_bit("rst_error", error, 1'b0);
    chk_val("rst_addr", 64'(mgmt_address), 64'd0);
    reset = 1'b0;

    // quiet idle: request matches power-on mode
    tick(1000);
    chk_int("t1_no_writes", got_q.size(), 0);
    chk_bit("t1_busy", busy, 1'b0);
    chk_bit("t1_applied", mode_applied, 1'b0);

    // 0 -> 1 with waitrequest low: 4-cycle latency to first strobe
    clear_capture();
    push_seq(FRAC_ADJ);
    mode_req = 1'b1;
    tick(3);
    chk_bit("t2_busy_after_detect", busy, 1'b1);
    chk_bit("t2_no_write_yet", mgmt_write, 1'b0);
    tick(1);
    chk_bit("t2_first_strobe", mgmt_write, 1'b1);
    wait_done("t2_done", 100);
    chk_bit("t2_applied", mode_applied, 1'b1);
    chk_bit("t2_busy_clr", busy, 1'b0);
    chk_bit("t2_error", error, 1'b0);
    compare_writes("t2");
    if (got_cyc.size() >= 3) begin
      chk_int("t2_gap1", got_cyc[1] - got_cyc[0], 2);
      chk_int("t2_gap2", got_cyc[2] - got_cyc[1], 2);
    end
    tick(1);
    chk_bit("t2_done_pulse", done, 1'b0);
    chk_int("t2_strobe_width", b2b, 0);

    // 1 -> 0 with lock lost: timeout, retry, then success
    clear_capture();
    push_seq(FRAC_NATIVE);
    push_seq(FRAC_NATIVE);
    pll_locked = 1'b0;
    mode_req = 1'b0;
    n = 0;
    while (error !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    chk_bit("t4_error_set", error, 1'b1);
    chk_bit("t4_busy_clr", busy, 1'b0);
    chk_bit("t4_applied_kept", mode_applied, 1'b1);
    chk_bit("t4_no_done", done, 1'b0);
    if (got_cyc.size() >= 3)
      chk_bit("t4_timeout_len", (cyc - got_cyc[2] >= 100) && (cyc - got_cyc[2] <= 110), 1'b1);
    tick(1);
    chk_bit("t4_retry_busy", busy, 1'b1);
    pll_locked = 1'b1;
    wait_done("t4_done", 200);
    chk_bit("t4_error_clr", error, 1'b0);
    chk_bit("t4_applied", mode_applied, 1'b0);
    compare_writes("t4");

    // 0 -> 1 with waitrequest held high ahead of the fractional write
    tick(5);
    clear_capture();
    push_seq(FRAC_ADJ);
    mode_req = 1'b1;
    wait_write("t3_mode_write", 50);
    mgmt_waitrequest = 1'b1;
    hi = 0;
    repeat (50) begin
      tick(1);
      if (mgmt_write) hi++;
    end
    chk_int("t3_no_strobe_hold", hi, 0);
    chk_bit("t3_busy_hold", busy, 1'b1);
    mgmt_waitrequest = 1'b0;
    tick(1);
    chk_bit("t3_strobe_after_release", mgmt_write, 1'b1);
    chk_val("t3_addr", 64'(mgmt_address), 64'd7);
    chk_val("t3_data", 64'(mgmt_writedata), 64'(FRAC_ADJ));
    tick(1);
    chk_val("t3_addr_held", 64'(mgmt_address), 64'd7);
    wait_done("t3_done", 100);
    chk_bit("t3_applied", mode_applied, 1'b1);
    compare_writes("t3");

    // reset during the fractional-write hold aborts, then a full rerun
    tick(5);
    clear_capture();
    mode_req = 1'b0;
    wait_write("t5_mode_write", 50);
    mgmt_waitrequest = 1'b1;
    tick(10);
    reset = 1'b1;
    tick(1);
    chk_bit("t5_write_low", mgmt_write, 1'b0);
    chk_bit("t5_busy_low", busy, 1'b0);
    chk_bit("t5_applied_low", mode_applied, 1'b0);
    mode_req = 1'b1;
    tick(3);
    chk_int("t5_writes_before_rst", got_q.size(), 1);
    mgmt_waitrequest = 1'b0;
    clear_capture();
    push_seq(FRAC_ADJ);
    reset = 1'b0;
    wait_done("t5_done", 100);
    chk_bit("t5_applied", mode_applied, 1'b1);
    compare_writes("t5");

    // single-cycle glitch while idle is rejected
    tick(5);
    clear_capture();
    mode_req = 1'b0;
    tick(1);
    mode_req = 1'b1;
    tick(20);
    chk_bit("t6_glitch_busy", busy, 1'b0);
    chk_int("t6_glitch_writes", got_q.size(), 0);

    // request pulse during a running sequence is ignored afterwards
    clear_capture();
    push_seq(FRAC_NATIVE);
    mode_req = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    chk_bit("t6_seq_started", busy, 1'b1);
    tick(3);
    mode_req = 1'b1;
    tick(1);
    mode_req = 1'b0;
    wait_done("t6_done", 100);
    chk_bit("t6_applied", mode_applied, 1'b0);
    tick(60);
    chk_bit("t6_no_rerun", busy, 1'b0);
    compare_writes("t6");
    chk_int("t6_strobe_width", b2b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
